// File: rtl/asyn_fifo_wr_ctrl.sv
// Write-side controller of a dual-clock FIFO: owns the write pointers, synchronises the
// read Gray pointer and derives full / almost-full / occupancy / overflow status.
module asyn_fifo_wr_ctrl #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned AF_LEVEL   = 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_wr_req,
   input  logic [ADDR_WIDTH:0]   i_rd_ptr_gray,
   output logic                  o_wr_en,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [ADDR_WIDTH:0]   o_wr_ptr_gray,
   output logic                  o_full,
   output logic                  o_almost_full,
   output logic [ADDR_WIDTH:0]   o_wr_count,
   output logic                  o_overflow
);

   localparam int unsigned PW = ADDR_WIDTH + 1;

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] wgray_next;
   logic [PW-1:0] rq1;
   logic [PW-1:0] rq2;
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] full_match;
   logic          push;

   // Two-flop synchroniser for the read-domain Gray pointer
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rq1 <= '0;
         rq2 <= '0;
      end else begin
         rq1 <= i_rd_ptr_gray;
         rq2 <= rq1;
      end
   end

   assign push       = i_wr_req & ~o_full;
   assign wbin_next  = wbin + PW'(push);
   assign wgray_next = wbin_next ^ (wbin_next >> 1);

   // Full when the next write pointer sits exactly one lap ahead of the synced read pointer
   assign full_match = {~rq2[PW-1:PW-2], rq2[PW-3:0]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wbin          <= '0;
         o_wr_ptr_gray <= '0;
         o_full        <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         wbin          <= wbin_next;
         o_wr_ptr_gray <= wgray_next;
         o_full        <= (wgray_next == full_match);
         o_overflow    <= i_wr_req & o_full;
      end
   end

   always_comb begin
      rbin_s = '0;
      for (int i = 0; i < int'(PW); i++) begin
         rbin_s[i] = ^(rq2 >> i);
      end
   end

   // Occupancy is pessimistic: the read pointer is seen two write clocks late
   assign o_wr_count    = wbin - rbin_s;
   assign o_almost_full = (o_wr_count >= PW'(AF_LEVEL));
   assign o_wr_addr     = wbin[ADDR_WIDTH-1:0];
   assign o_wr_en       = push;

endmodule

// File: tb/tb_asyn_fifo_wr_ctrl.sv
// Randomised bench for asyn_fifo_wr_ctrl against an integer occupancy model.
module tb_asyn_fifo_wr_ctrl;

   localparam int unsigned AW    = 3;
   localparam int unsigned AF    = 6;
   localparam int          DEPTH = 8;
   localparam int          MODV  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_req = 1'b0;
   logic [AW:0]   rd_gray = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   wr_gray;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wr_count;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   // reference state: pointers as plain integers
   int m_wr   = 0;
   int rd_bin = 0;
   int m_rq1  = 0;
   int m_rq2  = 0;
   bit m_full = 0;
   bit m_ovf  = 0;

   asyn_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wr_req      (wr_req),
      .i_rd_ptr_gray (rd_gray),
      .o_wr_en       (wr_en),
      .o_wr_addr     (wr_addr),
      .o_wr_ptr_gray (wr_gray),
      .o_full        (full),
      .o_almost_full (almost_full),
      .o_wr_count    (wr_count),
      .o_overflow    (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [AW:0] to_gray(input int b);
      logic [AW:0] v;
      v = (AW+1)'(b);
      return v ^ (v >> 1);
   endfunction

   // one clock: drive at negedge, check comb outputs, advance model at posedge, check after
   task automatic cycle(input bit req);
      bit          exp_en;
      int          wr_next;
      bit          new_full;
      int          occ;
      logic [AW:0] prev_gray;
      @(negedge clk);
      wr_req  = req;
      rd_gray = to_gray(rd_bin);
      #1;
      exp_en = req && !m_full;
      check("wr_en", 32'(wr_en), 32'(exp_en));
      check("wr_addr", 32'(wr_addr), 32'(m_wr % DEPTH));
      prev_gray = wr_gray;
      @(posedge clk);
      wr_next  = (m_wr + int'(exp_en)) % MODV;
      new_full = (((wr_next - m_rq2 + MODV) % MODV) == DEPTH);
      m_ovf    = req && m_full;
      m_rq2    = m_rq1;
      m_rq1    = rd_bin;
      m_wr     = wr_next;
      m_full   = new_full;
      #1;
      occ = (m_wr - m_rq2 + MODV) % MODV;
      check("wr_gray", 32'(wr_gray), 32'(to_gray(m_wr)));
      check("gray_step", 32'($countones(wr_gray ^ prev_gray)), 32'(exp_en));
      check("full", 32'(full), 32'(m_full));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("wr_count", 32'(wr_count), 32'(occ));
      check("almost_full", 32'(almost_full), 32'(occ >= int'(AF)));
   endtask

   task automatic model_reset();
      m_wr = 0; rd_bin = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_ovf = 0;
   endtask

   // asynchronous reset applied between edges, outputs checked before any edge
   task automatic do_reset();
      @(negedge clk);
      wr_req  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_gray", 32'(wr_gray), 0);
      check("rst_full", 32'(full), 0);
      check("rst_almost_full", 32'(almost_full), 0);
      check("rst_wr_count", 32'(wr_count), 0);
      check("rst_overflow", 32'(overflow), 0);
      model_reset();
      rd_gray = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int avail;
      int step;
      do_reset();

      // fill from empty, then one rejected request
      for (int i = 0; i < DEPTH; i++) cycle(1'b1);
      check("fill_full", 32'(full), 1);
      check("fill_count", 32'(wr_count), 8);
      cycle(1'b1);
      check("ovf_pulse", 32'(overflow), 1);
      check("ovf_gray_hold", 32'(wr_gray), 32'(4'b1100));
      cycle(1'b0);
      check("ovf_one_cycle", 32'(overflow), 0);

      // release by one read
      rd_bin = 1;
      cycle(1'b0);
      cycle(1'b0);
      check("rel_count", 32'(wr_count), 7);
      check("rel_full_lag", 32'(full), 1);
      cycle(1'b0);
      check("rel_full_low", 32'(full), 0);

      // gray sequence from reset
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1);
      check("gray5", 32'(wr_gray), 32'(4'b0111));
      check("mid_count5", 32'(wr_count), 5);
      do_reset();
      cycle(1'b1);
      check("post_rst_gray", 32'(wr_gray), 1);

      // wrap with tracking reader
      do_reset();
      for (int i = 0; i < MODV; i++) begin
         rd_bin = (m_wr + MODV - 1) % MODV;
         if (i == 0) rd_bin = 0;
         cycle(1'b1);
      end
      check("wrap_gray", 32'(wr_gray), 0);
      check("wrap_no_full", 32'(full), 0);
      rd_bin = 8;
      repeat (3) cycle(1'b0);
      check("wrap_count8", 32'(wr_count), 8);
      check("wrap_full", 32'(full), 1);

      // almost-full threshold
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1);
      check("af_low5", 32'(almost_full), 0);
      cycle(1'b1);
      check("af_high6", 32'(almost_full), 1);
      rd_bin = 1;
      cycle(1'b0);
      check("af_hold", 32'(almost_full), 1);
      cycle(1'b0);
      check("af_drop", 32'(almost_full), 0);

      // randomised traffic with a reader that never passes the writer
      do_reset();
      for (int n = 0; n < 400; n++) begin
         avail = (m_wr - rd_bin + MODV) % MODV;
         if (avail > 2) avail = 2;
         step  = (($urandom % 3) == 0) ? int'($urandom_range(0, avail)) : 0;
         rd_bin = (rd_bin + step) % MODV;
         cycle(($urandom % 4) != 0);
         if (n == 200) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
